simt_scheduler: RTL and testbench
=================================

# simt_scheduler

Per-core SIMT scheduler: the parametrised successor to the fixed lock-step scheduler, adding per-thread program counters and minimum-PC reconvergence so that threads in a block may branch divergently and rejoin automatically. Sequences the core state machine, tracks a live mask (threads not yet returned) and an active mask (threads executing the current instruction), and selects the next shared fetch PC. Sits inside the core between the fetcher/decoder/LSUs/PC units and the program memory path; per-thread register files, ALUs and PCs are gated by `active_mask`.

## Interface
- `THREADS_PER_BLOCK`, 4: threads per core (N); 1..32.
- `PROGRAM_MEM_ADDR_BITS`, 8: PC width (P).
- `COUNTER_BITS`, 32: width of performance counters.

- `clk`  in  1  core clock; single clock domain.
- `reset`  in  1  synchronous, active-low: state cleared on any rising `clk` edge where `reset`=0.
- `start`  in  1  kernel launch pulse, sampled in IDLE only.
- `thread_count`  in  $clog2(N)+1  threads enabled for this block; values > N clamp to N.
- `fetcher_state`  in  3  fetcher state; 3'b010 = FETCHED.
- `decoded_mem_read_enable`, `decoded_mem_write_enable`, `decoded_ret`  in  1 each  decoder outputs.
- `lsu_state`  in  2 × N (unpacked)  per-thread LSU state; 2'b01 REQUESTING, 2'b10 WAITING.
- `next_pc`  in  P × N (unpacked)  per-thread PC-unit result for the current instruction.
- `core_state`  out  3  current state.
- `current_pc`  out  P  shared fetch PC.
- `active_mask`  out  N  threads executing current instruction.
- `live_mask`  out  N  threads not yet retired.
- `diverged`  out  1  `active_mask != live_mask`.
- `instr_count`, `diverge_count`  out  COUNTER_BITS  issued instructions; issues with divergence.
- `done`  out  1  block complete.

## Operation
- States (3-bit): IDLE 0, FETCH 1, DECODE 2, REQUEST 3, WAIT 4, EXECUTE 5, UPDATE 6, DONE 7.
- Internal `thread_pc[N]`, P bits each.
- IDLE: on `start`=1 → `live_mask`=`active_mask`=low `thread_count` bits set, all `thread_pc`=0, `current_pc`=0, go FETCH; if clamped `thread_count`=0, go DONE directly.
- FETCH → DECODE when `fetcher_state`=3'b010; otherwise hold.
- DECODE → REQUEST → WAIT, one cycle each.
- WAIT: hold while any thread i with `active_mask[i]`=1 has `lsu_state[i]` ∈ {01,10}; otherwise → EXECUTE. Inactive threads' LSU states ignored.
- EXECUTE → UPDATE, one cycle.
- UPDATE (single cycle, all computed combinationally from pre-edge values):
  - live' = `decoded_ret` ? live & ~active : live.
  - pc'[i] = active[i] ? `next_pc[i]` : `thread_pc[i]`; registered into `thread_pc`.
  - live'=0 → DONE. Else min = unsigned minimum of pc'[i] over live'; `current_pc`←min; `active_mask`←live' & (pc'==min); → FETCH.
  - `instr_count`+1; `diverge_count`+1 if new active ≠ live'. Counters wrap at 2^COUNTER_BITS.
- DONE: `done`=1, `active_mask`=0; held until reset; `start` ignored.
- Threads ≥ `thread_count` never enter `live_mask`; their `next_pc`/`lsu_state` never affect behaviour.

## Timing
- Reset values: `core_state`=IDLE, `current_pc`=0, all `thread_pc`=0, `active_mask`=0, `live_mask`=0, `diverged`=0, counters 0, `done`=0.
- `start` seen at edge k → FETCH from k+1.
- Non-memory instruction with fetch latency F: F+5 cycles FETCH entry to next FETCH entry (FETCH F, DECODE, REQUEST, WAIT, EXECUTE, UPDATE).
- Memory instruction: WAIT extends until last active LSU leaves 01/10; EXECUTE on the following cycle.
- `done` rises the cycle after the UPDATE that empties `live_mask`.
- All outputs registered except `diverged` (combinational from registered masks).
- Reset mid-kernel (any state): all outputs at reset values after that edge; in-flight instruction abandoned.
- `start` asserted during non-IDLE states: no effect.

## Structure
- Package `simt_pkg`: `core_state_t` enum (8 states above), FETCHED constant, LSU state constants.
- Sub-module `min_pc_select`: combinational, parameters N/P; inputs pc'[N], mask; outputs min PC and match mask. Log-depth tree.
- Scheduler FSM, masks, thread PCs, counters in `simt_scheduler`.

## Test plan
- Uniform: N=4, `thread_count`=4, all `next_pc`=pc+1, RET at PC 3 → `active_mask`=4'b1111 throughout, `instr_count`=4, `diverge_count`=0, `done`.
- Divergence: at PC 2 threads 0,1 `next_pc`=3, threads 2,3 `next_pc`=6 → next `active_mask`=4'b0011 at PC 3, `diverged`=1; after those reach 6 → 4'b1111, `diverged`=0.
- Partial retire: threads 0,1 RET at PC 4 while 2,3 active elsewhere → `live_mask`=4'b1100, `done` only after 2,3 RET.
- Memory stall: active thread 1 holds `lsu_state`=10 for 7 cycles, inactive thread 3 holds 01 → WAIT exactly 8 cycles, ignores thread 3.
- Clamp/zero: `thread_count`=7 with N=4 → `live_mask`=4'b1111; `thread_count`=0 → DONE one cycle after `start`, `instr_count`=0.
- Reset mid-WAIT with `reset`=0 for one edge → all outputs reset values; subsequent `start` runs kernel normally.

Source files
------------

// File: rtl/simt_pkg.sv
// Shared types and encodings for the SIMT scheduler: core state machine,
// fetcher handshake value and LSU busy encodings.
package simt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_REQUEST = 3'd3,
    ST_WAIT    = 3'd4,
    ST_EXECUTE = 3'd5,
    ST_UPDATE  = 3'd6,
    ST_DONE    = 3'd7
  } core_state_t;

  localparam logic [2:0] FETCHER_FETCHED = 3'b010;

  localparam logic [1:0] LSU_REQUESTING = 2'b01;
  localparam logic [1:0] LSU_WAITING    = 2'b10;

  // A thread's LSU holds the pipeline while it is requesting or waiting.
  function automatic logic lsu_is_busy(input logic [1:0] s);
    return (s == LSU_REQUESTING) || (s == LSU_WAITING);
  endfunction

endpackage

// File: rtl/simt_scheduler_if.sv
// Scheduler-side bundle: launch control, fetch/decode/LSU/PC-unit inputs and
// the scheduler's masks, PC, counters and completion flag.
interface simt_scheduler_if
  import simt_pkg::*;
#(
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int COUNTER_BITS          = 32
);
  localparam int N = THREADS_PER_BLOCK;
  localparam int P = PROGRAM_MEM_ADDR_BITS;

  logic                    start;
  logic [$clog2(N):0]      thread_count;
  logic [2:0]              fetcher_state;
  logic                    decoded_mem_read_enable;
  logic                    decoded_mem_write_enable;
  logic                    decoded_ret;
  logic [1:0]              lsu_state [N];
  logic [P-1:0]            next_pc [N];

  core_state_t             core_state;
  logic [P-1:0]            current_pc;
  logic [N-1:0]            active_mask;
  logic [N-1:0]            live_mask;
  logic                    diverged;
  logic [COUNTER_BITS-1:0] instr_count;
  logic [COUNTER_BITS-1:0] diverge_count;
  logic                    done;

  modport master (
    output start, thread_count, fetcher_state, decoded_mem_read_enable,
           decoded_mem_write_enable, decoded_ret, lsu_state, next_pc,
    input  core_state, current_pc, active_mask, live_mask, diverged,
           instr_count, diverge_count, done
  );

  modport slave (
    input  start, thread_count, fetcher_state, decoded_mem_read_enable,
           decoded_mem_write_enable, decoded_ret, lsu_state, next_pc,
    output core_state, current_pc, active_mask, live_mask, diverged,
           instr_count, diverge_count, done
  );

endinterface

// File: rtl/min_pc_select.sv
// Reconvergence selector: unsigned minimum PC over the masked threads (binary
// tree, log depth) and the mask of masked threads sitting at that PC.
module min_pc_select #(
  parameter int N = 4,
  parameter int P = 8
) (
  input  logic [P-1:0] pc [N],
  input  logic [N-1:0] mask,
  output logic [P-1:0] min_pc,
  output logic [N-1:0] match
);
  localparam int L = (N > 1) ? $clog2(N) : 0;
  localparam int S = 1 << L;

  // Heap layout: node k has children 2k+1 and 2k+2; leaves start at S-1.
  always_comb begin : tree
    logic [P-1:0] val [2*S-1];
    logic         vld [2*S-1];
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    for (int k = 0; k < 2*S-1; k++) begin
      val[k] = '0;
      vld[k] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      val[S-1+i] = pc[i];
      vld[S-1+i] = mask[i];
    end
    for (int k = S-2; k >= 0; k--) begin
      if (vld[2*k+1] && (!vld[2*k+2] || (val[2*k+1] <= val[2*k+2]))) begin
        val[k] = val[2*k+1];
        vld[k] = 1'b1;
      end else begin
        val[k] = val[2*k+2];
        vld[k] = vld[2*k+2];
      end
    end
    min_pc = val[0];
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < N; i++) match[i] = mask[i] && (pc[i] == min_pc);
  end

endmodule

// File: rtl/simt_scheduler.sv
// Per-core SIMT scheduler: core FSM, live/active masks, per-thread PCs with
// minimum-PC reconvergence, and issue/divergence counters.
module simt_scheduler
  import simt_pkg::*;
#(
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int COUNTER_BITS          = 32
) (
  input logic            clk,
  input logic            reset,
  simt_scheduler_if.slave bus
);
  localparam int N  = THREADS_PER_BLOCK;
  localparam int P  = PROGRAM_MEM_ADDR_BITS;
  localparam int C  = COUNTER_BITS;
  localparam int TW = $clog2(N) + 1;

  core_state_t   state_q, state_d;
  logic [P-1:0]  thread_pc_q [N];
  logic [P-1:0]  pc_upd [N];
  logic [P-1:0]  current_pc_q, min_pc;
  logic [N-1:0]  active_q, live_q, live_upd, match, launch_mask, lsu_busy;
  logic [TW-1:0] tc_clamped;
  logic [C-1:0]  instr_q, diverge_q;
  logic          done_q;
  logic          unused_decode;

  assign unused_decode = bus.decoded_mem_read_enable ^ bus.decoded_mem_write_enable;

  always_comb begin
    tc_clamped  = (int'(bus.thread_count) > N) ? TW'(N) : bus.thread_count;
    launch_mask = '0;
    for (int i = 0; i < N; i++) launch_mask[i] = (i < int'(tc_clamped));
  end

  // Only threads executing the current instruction can stall WAIT.
  always_comb begin
    lsu_busy = '0;
    for (int i = 0; i < N; i++) lsu_busy[i] = active_q[i] && lsu_is_busy(bus.lsu_state[i]);
  end

  always_comb begin
    live_upd = bus.decoded_ret ? (live_q & ~active_q) : live_q;
    for (int i = 0; i < N; i++) pc_upd[i] = active_q[i] ? bus.next_pc[i] : thread_pc_q[i];
  end

  min_pc_select #(.N(N), .P(P)) u_min_pc (
    .pc     (pc_upd),
    .mask   (live_upd),
    .min_pc (min_pc),
    .match  (match)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus.start) state_d = (launch_mask == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH:   if (bus.fetcher_state == FETCHER_FETCHED) state_d = ST_DECODE;
      ST_DECODE:  state_d = ST_REQUEST;
      ST_REQUEST: state_d = ST_WAIT;
      ST_WAIT:    if (lsu_busy == '0) state_d = ST_EXECUTE;
      ST_EXECUTE: state_d = ST_UPDATE;
      ST_UPDATE:  state_d = (live_upd == '0) ? ST_DONE : ST_FETCH;
      ST_DONE:    state_d = ST_DONE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      current_pc_q <= '0;
      active_q     <= '0;
      live_q       <= '0;
      instr_q      <= '0;
      diverge_q    <= '0;
      done_q       <= 1'b0;
      // NOTE: the thread PC array is small flop storage, not RAM, so it is reset like any register.
      for (int i = 0; i < N; i++) thread_pc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == ST_DONE);
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            live_q       <= launch_mask;
            active_q     <= launch_mask;
            current_pc_q <= '0;
            for (int i = 0; i < N; i++) thread_pc_q[i] <= '0;
          end
        end
        ST_UPDATE: begin
          live_q   <= live_upd;
          active_q <= match;
          if (live_upd != '0) current_pc_q <= min_pc;
          for (int i = 0; i < N; i++) thread_pc_q[i] <= pc_upd[i];
          instr_q <= instr_q + C'(1);
          if (match != live_upd) diverge_q <= diverge_q + C'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.core_state    = state_q;
  assign bus.current_pc    = current_pc_q;
  assign bus.active_mask   = active_q;
  assign bus.live_mask     = live_q;
  assign bus.diverged      = (active_q != live_q);
  assign bus.instr_count   = instr_q;
  assign bus.diverge_count = diverge_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_simt_scheduler.sv
// Self-checking bench for simt_scheduler: small programs (directed and random)
// run against an instruction-level min-PC reconvergence model.
module tb_simt_scheduler;
  import simt_pkg::*;

  localparam int N    = 4;
  localparam int P    = 8;
  localparam int C    = 32;
  localparam int PMAX = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  simt_scheduler_if #(.THREADS_PER_BLOCK(N), .PROGRAM_MEM_ADDR_BITS(P), .COUNTER_BITS(C)) bus ();

  simt_scheduler #(.THREADS_PER_BLOCK(N), .PROGRAM_MEM_ADDR_BITS(P), .COUNTER_BITS(C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  // Program: per-thread branch targets, shared RET/memory flags, LSU stall lengths.
  logic [P-1:0] prog_next  [N][PMAX];
  bit           prog_ret   [PMAX];
  bit           prog_mem   [PMAX];
  int           prog_stall [N][PMAX];

  int           exp_pc   [$];
  logic [N-1:0] exp_act  [$];
  logic [N-1:0] exp_live [$];
  int           exp_instr, exp_div;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0;
    bus.fetcher_state = 3'b000;
    bus.decoded_mem_read_enable = 1'b0;
    bus.decoded_mem_write_enable = 1'b0;
    bus.decoded_ret = 1'b0;
    for (int i = 0; i < N; i++) begin
      bus.lsu_state[i] = 2'b00;
      bus.next_pc[i] = '0;
    end
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic clear_prog();
    for (int pc = 0; pc < PMAX; pc++) begin
      prog_ret[pc] = (pc == PMAX-1);
      prog_mem[pc] = 1'b0;
      for (int i = 0; i < N; i++) begin
        prog_next[i][pc]  = P'((pc < PMAX-1) ? pc + 1 : pc);
        prog_stall[i][pc] = 0;
      end
    end
  endtask

  task automatic random_prog();
    for (int pc = 0; pc < PMAX; pc++) begin
      prog_ret[pc] = (pc == PMAX-1) || ($urandom_range(0, 5) == 0);
      prog_mem[pc] = $urandom_range(0, 1) == 1;
      for (int i = 0; i < N; i++) begin
        prog_next[i][pc]  = P'((pc < PMAX-1) ? pc + 1 + int'($urandom_range(0, 2)) % (PMAX-1-pc) : pc);
        prog_stall[i][pc] = $urandom_range(0, 4);
      end
    end
  endtask

  // Instruction-level reference: issue at the lowest PC among live threads.
  task automatic model_run(input int tc);
    int           ntc, mn;
    int           pcs [N];
    logic [N-1:0] live, act;
    exp_pc.delete();
    exp_act.delete();
    exp_live.delete();
    exp_instr = 0;
    exp_div = 0;
    ntc = (tc > N) ? N : tc;
    live = '0;
    for (int i = 0; i < N; i++) begin
      pcs[i] = 0;
      if (i < ntc) live[i] = 1'b1;
    end
    while (live != '0 && exp_instr < 500) begin
      mn = 1 << P;
      for (int i = 0; i < N; i++) if (live[i] && pcs[i] < mn) mn = pcs[i];
      act = '0;
      for (int i = 0; i < N; i++) if (live[i] && pcs[i] == mn) act[i] = 1'b1;
      if (exp_instr > 0 && act != live) exp_div++;
      exp_pc.push_back(mn);
      exp_act.push_back(act);
      exp_live.push_back(live);
      for (int i = 0; i < N; i++) if (act[i]) pcs[i] = int'(prog_next[i][mn]);
      if (prog_ret[mn]) live &= ~act;
      exp_instr++;
    end
  endtask

  task automatic expect_state(input string name, input core_state_t want);
    vectors++;
    if (bus.core_state !== want) begin
      miscompares++;
      $display("FAIL %s: core_state got %0d want %0d", name, bus.core_state, want);
    end
  endtask

  // Launches a kernel and walks it instruction by instruction, driving the
  // fetcher/decoder/LSU/PC-unit side from the program tables.
  task automatic run_kernel(input string name, input int tc, input bit do_reset);
    int           pc, f, n, exp_wait, s;
    logic [N-1:0] act;
    if (do_reset) apply_reset();
    model_run(tc);
    bus.thread_count = ($clog2(N)+1)'(tc);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < exp_pc.size(); k++) begin
      pc  = exp_pc[k];
      act = exp_act[k];
      expect_state({name, "_fetch"}, ST_FETCH);
      vectors++;
      if (bus.current_pc !== P'(pc) || bus.active_mask !== act || bus.live_mask !== exp_live[k]
          || bus.diverged !== (act != exp_live[k])) begin
        miscompares++;
        $display("FAIL %s_issue%0d: pc/act/live/div got %0d/%b/%b/%b want %0d/%b/%b/%b", name, k,
                 bus.current_pc, bus.active_mask, bus.live_mask, bus.diverged,
                 pc, act, exp_live[k], act != exp_live[k]);
      end
      bus.decoded_ret = prog_ret[pc];
      bus.decoded_mem_read_enable = prog_mem[pc];
      bus.decoded_mem_write_enable = 1'b0;
      for (int i = 0; i < N; i++) bus.next_pc[i] = act[i] ? prog_next[i][pc] : P'($urandom);
      f = $urandom_range(1, 3);
      for (int c = 1; c <= f; c++) begin
        bus.fetcher_state = (c == f) ? FETCHER_FETCHED : 3'($urandom_range(0, 1));
        tick();
      end
      bus.fetcher_state = 3'b000;
      expect_state({name, "_decode"}, ST_DECODE);
      tick();
      expect_state({name, "_request"}, ST_REQUEST);
      tick();
      exp_wait = 1;
      for (int i = 0; i < N; i++)
        if (act[i] && prog_mem[pc] && prog_stall[i][pc] + 1 > exp_wait) exp_wait = prog_stall[i][pc] + 1;
      n = 0;
      while (bus.core_state == ST_WAIT && n < 64) begin
        for (int i = 0; i < N; i++) begin
          s = prog_mem[pc] ? prog_stall[i][pc] : 0;
          if (!act[i]) bus.lsu_state[i] = $urandom_range(0, 1) ? LSU_REQUESTING : LSU_WAITING;
          else bus.lsu_state[i] = (n + 1 <= s) ? (n[0] ? LSU_WAITING : LSU_REQUESTING) : 2'b00;
        end
        tick();
        n++;
      end
      for (int i = 0; i < N; i++) bus.lsu_state[i] = 2'b00;
      vectors++;
      if (n !== exp_wait) begin
        miscompares++;
        $display("FAIL %s_wait%0d: wait cycles got %0d want %0d", name, k, n, exp_wait);
      end
      expect_state({name, "_execute"}, ST_EXECUTE);
      tick();
      expect_state({name, "_update"}, ST_UPDATE);
      tick();
    end
    expect_state({name, "_end"}, ST_DONE);
    vectors++;
    if (bus.done !== 1'b1 || bus.active_mask !== '0 || bus.live_mask !== '0
        || bus.instr_count !== C'(exp_instr) || bus.diverge_count !== C'(exp_div)) begin
      miscompares++;
      $display("FAIL %s_final: done/act/live/instr/div got %b/%b/%b/%0d/%0d want 1/0/0/%0d/%0d", name,
               bus.done, bus.active_mask, bus.live_mask, bus.instr_count, bus.diverge_count,
               exp_instr, exp_div);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    expect_state({name, "_done_hold"}, ST_DONE);
  endtask

  task automatic test_reset();
    apply_reset();
    expect_state("reset", ST_IDLE);
    vectors++;
    if (bus.current_pc !== '0 || bus.active_mask !== '0 || bus.live_mask !== '0 || bus.diverged !== 1'b0
        || bus.instr_count !== '0 || bus.diverge_count !== '0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: pc/act/live/div/ic/dc/done got %0d/%b/%b/%b/%0d/%0d/%b want all zero",
               bus.current_pc, bus.active_mask, bus.live_mask, bus.diverged,
               bus.instr_count, bus.diverge_count, bus.done);
    end
  endtask

  task automatic test_uniform();
    clear_prog();
    prog_ret[3] = 1'b1;
    run_kernel("uniform", 4, 1'b1);
  endtask

  task automatic test_divergence();
    clear_prog();
    prog_next[0][2] = 8'd3;
    prog_next[1][2] = 8'd3;
    prog_next[2][2] = 8'd6;
    prog_next[3][2] = 8'd6;
    prog_ret[6] = 1'b1;
    run_kernel("divergence", 4, 1'b1);
  endtask

  task automatic test_partial_retire();
    clear_prog();
    prog_next[0][0] = 8'd4;
    prog_next[1][0] = 8'd4;
    prog_next[2][0] = 8'd5;
    prog_next[3][0] = 8'd5;
    prog_next[2][5] = 8'd7;
    prog_next[3][5] = 8'd7;
    prog_ret[4] = 1'b1;
    prog_ret[7] = 1'b1;
    run_kernel("partial_retire", 4, 1'b1);
  endtask

  task automatic test_mem_stall();
    clear_prog();
    prog_ret[2] = 1'b1;
    prog_mem[1] = 1'b1;
    prog_stall[1][1] = 7;
    run_kernel("mem_stall", 3, 1'b1);
  endtask

  task automatic test_clamp_zero();
    clear_prog();
    prog_ret[1] = 1'b1;
    run_kernel("clamp", 7, 1'b1);
    run_kernel("zero", 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int n;
    clear_prog();
    apply_reset();
    bus.thread_count = 3'd4;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.fetcher_state = FETCHER_FETCHED;
    for (int i = 0; i < N; i++) bus.lsu_state[i] = LSU_WAITING;
    n = 0;
    while (bus.core_state != ST_WAIT && n < 20) begin
      tick();
      n++;
    end
    expect_state("reset_mid_reach_wait", ST_WAIT);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    idle_inputs();
    expect_state("reset_mid_state", ST_IDLE);
    vectors++;
    if (bus.current_pc !== '0 || bus.active_mask !== '0 || bus.live_mask !== '0 || bus.diverged !== 1'b0
        || bus.instr_count !== '0 || bus.diverge_count !== '0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: pc/act/live/div/ic/dc/done got %0d/%b/%b/%b/%0d/%0d/%b want all zero",
               bus.current_pc, bus.active_mask, bus.live_mask, bus.diverged,
               bus.instr_count, bus.diverge_count, bus.done);
    end
    random_prog();
    run_kernel("after_reset_mid", 4, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      random_prog();
      run_kernel($sformatf("random%0d", t), $urandom_range(0, 7), 1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.thread_count = '0;
    idle_inputs();
    test_reset();
    test_uniform();
    test_divergence();
    test_partial_retire();
    test_mem_stall();
    test_clamp_zero();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
